// File: rtl/fp_mul_arbiter.sv
// fp_mul_arbiter: round-robin sharing of one Q(I).(F) multiplier among N_REQ
// valid/ready requesters, with a single response bus and debug counters.
// Ports: clk, rst_n; req_valid/req_ready/req_a/req_b/req_s1/req_s2 (packed per
// requester); rsp_valid/rsp_ready/rsp_id/rsp_c/rsp_sign/rsp_overflow;
// stat_clr, op_cnt, ovf_cnt.

module fp_mul_dp #(
  parameter  int I = 2,
  parameter  int F = 14,
  localparam int W = I + F
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         s1,
  input  logic         s2,
  output logic [W-1:0] c,
  output logic         sign,
  output logic         overflow
);
  logic signed [W:0]     ax;
  logic signed [W:0]     bx;
  logic signed [2*W+1:0] p;
  logic signed [2*W+1:0] q;
  logic                  rs;
  logic                  ovf_s;
  logic                  ovf_u;

  assign ax = {s1 & a[W-1], a};
  assign bx = {s2 & b[W-1], b};
  assign p  = (2*W+2)'(ax) * (2*W+2)'(bx);
  // Arithmetic shift truncates the F dropped LSBs toward minus infinity.
  assign q  = p >>> F;

  // The result range is signed whenever either operand is signed, since a
  // signed operand can make the product negative.
  assign rs    = s1 | s2;
  assign ovf_s = !((&q[2*W+1:W-1]) || !(|q[2*W+1:W-1]));
  assign ovf_u = |q[2*W+1:W];

  assign overflow = rs ? ovf_s : ovf_u;
  assign c        = overflow ? '1 : q[W-1:0];
  assign sign     = s1 ^ s2;
endmodule

module fp_mul_arbiter #(
  parameter  int N_REQ = 4,
  parameter  int I     = 2,
  parameter  int F     = 14,
  parameter  int CNT_W = 16,
  localparam int W     = I + F,
  localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [N_REQ*W-1:0] req_a,
  input  logic [N_REQ*W-1:0] req_b,
  input  logic [N_REQ-1:0]   req_s1,
  input  logic [N_REQ-1:0]   req_s2,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [ID_W-1:0]    rsp_id,
  output logic [W-1:0]       rsp_c,
  output logic               rsp_sign,
  output logic               rsp_overflow,
  input  logic               stat_clr,
  output logic [CNT_W-1:0]   op_cnt,
  output logic [CNT_W-1:0]   ovf_cnt
);
  typedef enum logic [1:0] {IDLE, MUL, RESP} state_t;

  state_t          state;
  logic [ID_W-1:0] last;
  logic [ID_W-1:0] gnt_id;
  logic            gnt_any;
  logic [ID_W-1:0] op_id;
  logic [W-1:0]    op_a;
  logic [W-1:0]    op_b;
  logic            op_s1;
  logic            op_s2;
  logic [W-1:0]    dp_c;
  logic            dp_sign;
  logic            dp_ovf;
  logic            done;

  // First requesting index after the last winner, wrapping around.
  always_comb begin
    int k;
    k       = 0;
    gnt_any = 1'b0;
    gnt_id  = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      k = int'(last) + i;
      if (k >= N_REQ) k = k - N_REQ;
      if (!gnt_any && req_valid[ID_W'(k)]) begin
        gnt_any = 1'b1;
        gnt_id  = ID_W'(k);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (rst_n && state == IDLE && gnt_any)
      req_ready[gnt_id] = 1'b1;
  end

  fp_mul_dp #(.I(I), .F(F)) u_dp (
    .a        (op_a),
    .b        (op_b),
    .s1       (op_s1),
    .s2       (op_s2),
    .c        (dp_c),
    .sign     (dp_sign),
    .overflow (dp_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      last         <= ID_W'(N_REQ - 1);
      op_id        <= '0;
      op_a         <= '0;
      op_b         <= '0;
      op_s1        <= 1'b0;
      op_s2        <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_id       <= '0;
      rsp_c        <= '0;
      rsp_sign     <= 1'b0;
      rsp_overflow <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (gnt_any) begin
            op_a  <= req_a[gnt_id*W +: W];
            op_b  <= req_b[gnt_id*W +: W];
            op_s1 <= req_s1[gnt_id];
            op_s2 <= req_s2[gnt_id];
            op_id <= gnt_id;
            last  <= gnt_id;
            state <= MUL;
          end
        end
        MUL: begin
          rsp_c        <= dp_c;
          rsp_sign     <= dp_sign;
          rsp_overflow <= dp_ovf;
          rsp_id       <= op_id;
          rsp_valid    <= 1'b1;
          state        <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign done = rsp_valid & rsp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_cnt  <= '0;
      ovf_cnt <= '0;
    end else if (stat_clr) begin
      op_cnt  <= '0;
      ovf_cnt <= '0;
    end else if (done) begin
      if (op_cnt != '1)
        op_cnt <= op_cnt + CNT_W'(1);
      if (rsp_overflow && ovf_cnt != '1)
        ovf_cnt <= ovf_cnt + CNT_W'(1);
    end
  end
endmodule
